// File: rtl/gray_step_monitor.sv
// gray_step_monitor: decodes a sampled Gray code to binary. It checks that each
// valid sample is one count (mod 2^CBITS) ahead of the previous one. Lock is
// acquired after LOCK_N good steps. While locked, a bad step produces a pulse on
// step_err and is added to a saturating error count.
module gray_step_monitor #(
    parameter int CBITS  = 8,
    parameter int LOCK_N = 4,
    parameter int ECW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CBITS-1:0] gray_in,
    input  logic             gray_vld,
    input  logic             clr_err,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_vld,
    output logic             locked,
    output logic             wrap,
    output logic             step_err,
    output logic             err_sticky,
    output logic [ECW-1:0]   err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        TRACK
    } state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_N);

    state_t           state, state_nx;
    logic [3:0]       good_cnt, good_cnt_nx, good_inc;
    logic [CBITS-1:0] prev, prev_nx;
    logic [CBITS-1:0] dec;
    logic [CBITS-1:0] bin_out_nx;
    logic             bin_vld_nx, wrap_nx, step_err_nx, err_sticky_nx;
    logic [ECW-1:0]   err_cnt_nx;
    logic             is_good, is_hold;

    // Gray to binary: each bit is the XOR of all Gray bits at or above it
    always_comb begin
        dec = '0;
        dec[CBITS-1] = gray_in[CBITS-1];
        for (int unsigned i = 1; i < CBITS; i++) begin
            dec[CBITS-1-i] = dec[CBITS-i] ^ gray_in[CBITS-1-i];
        end
    end

    // Step classification, next-state and next-output logic
    always_comb begin
        state_nx      = state;
        good_cnt_nx   = good_cnt;
        prev_nx       = prev;
        bin_out_nx    = bin_out;
        bin_vld_nx    = 1'b0;
        wrap_nx       = 1'b0;
        step_err_nx   = 1'b0;
        err_sticky_nx = err_sticky;
        err_cnt_nx    = err_cnt;
        good_inc      = good_cnt + 4'd1;
        is_good       = (dec == prev + CBITS'(1));
        is_hold       = (dec == prev);

        if (gray_vld) begin
            bin_out_nx = dec;
            bin_vld_nx = 1'b1;
            prev_nx    = dec;
            case (state)
                IDLE: begin
                    state_nx    = LOCK;
                    good_cnt_nx = '0;
                end
                LOCK: begin
                    if (is_good) begin
                        wrap_nx     = (prev == '1);
                        good_cnt_nx = good_inc;
                        if (good_inc == LOCK_TGT) begin
                            state_nx = TRACK;
                        end
                    end else if (!is_hold) begin
                        good_cnt_nx = '0;
                    end
                end
                TRACK: begin
                    if (is_good) begin
                        wrap_nx = (prev == '1);
                    end else if (!is_hold) begin
                        step_err_nx = 1'b1;
                        state_nx    = LOCK;
                        good_cnt_nx = '0;
                    end
                end
                default: begin
                    state_nx    = IDLE;
                    good_cnt_nx = '0;
                end
            endcase
        end

        // A simultaneous step error takes priority over clr_err.
        if (step_err_nx) begin
            err_sticky_nx = 1'b1;
            if (clr_err) begin
                err_cnt_nx = ECW'(1);
            end else if (err_cnt != '1) begin
                err_cnt_nx = err_cnt + ECW'(1);
            end
        end else if (clr_err) begin
            err_sticky_nx = 1'b0;
            err_cnt_nx    = '0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            good_cnt   <= '0;
            prev       <= '0;
            bin_out    <= '0;
            bin_vld    <= 1'b0;
            wrap       <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nx;
            good_cnt   <= good_cnt_nx;
            prev       <= prev_nx;
            bin_out    <= bin_out_nx;
            bin_vld    <= bin_vld_nx;
            wrap       <= wrap_nx;
            step_err   <= step_err_nx;
            err_sticky <= err_sticky_nx;
            err_cnt    <= err_cnt_nx;
        end
    end

    // locked is a direct decode of the TRACK state
    always_comb begin
        locked = (state == TRACK);
    end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Testbench for gray_step_monitor. It runs directed scenarios and then random
// stimulus. Every output is compared each cycle against a behavioural model.
// A second instance with ECW=2 checks saturation of the error counter.
module tb_gray_step_monitor;

    localparam int CBITS  = 8;
    localparam int LOCK_N = 4;
    localparam int MAXV   = (1 << CBITS) - 1;

    logic             clk = 1'b0;
    logic             rst_n, gray_vld, clr_err;
    logic [CBITS-1:0] gray_in;

    logic [CBITS-1:0] bin_out, bin_out2;
    logic             bin_vld, locked, wrap, step_err, err_sticky;
    logic             bin_vld2, locked2, wrap2, step_err2, err_sticky2;
    logic [7:0]       err_cnt;
    logic [1:0]       err_cnt2;

    int errors = 0;
    int checks = 0;

    // Model state: mode 0 = idle, 1 = acquiring, 2 = tracking
    int m_mode, m_gc, m_prev, m_bin, m_bvld, m_wrap, m_serr, m_sticky, m_cnt, m_cnt2;
    int inv_tab [0:MAXV];

    always #5 clk = ~clk;

    gray_step_monitor #(.CBITS(CBITS), .LOCK_N(LOCK_N), .ECW(8)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_vld(gray_vld),
        .clr_err(clr_err), .bin_out(bin_out), .bin_vld(bin_vld), .locked(locked),
        .wrap(wrap), .step_err(step_err), .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    gray_step_monitor #(.CBITS(CBITS), .LOCK_N(LOCK_N), .ECW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_vld(gray_vld),
        .clr_err(clr_err), .bin_out(bin_out2), .bin_vld(bin_vld2), .locked(locked2),
        .wrap(wrap2), .step_err(step_err2), .err_sticky(err_sticky2), .err_cnt(err_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge, using the inputs currently driven
    task automatic model_edge();
        int d;
        bit good, hold;
        if (!rst_n) begin
            m_mode = 0; m_gc = 0; m_prev = 0; m_bin = 0; m_bvld = 0;
            m_wrap = 0; m_serr = 0; m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
            return;
        end
        m_wrap = 0;
        m_serr = 0;
        m_bvld = 0;
        if (gray_vld) begin
            d    = inv_tab[int'(gray_in)];
            good = (d == ((m_prev + 1) % (MAXV + 1)));
            hold = (d == m_prev);
            m_bin  = d;
            m_bvld = 1;
            if (m_mode == 0) begin
                m_mode = 1;
                m_gc   = 0;
            end else if (good) begin
                m_wrap = (m_prev == MAXV && d == 0) ? 1 : 0;
                if (m_mode == 1) begin
                    m_gc++;
                    if (m_gc == LOCK_N) m_mode = 2;
                end
            end else if (!hold) begin
                if (m_mode == 2) m_serr = 1;
                m_mode = 1;
                m_gc   = 0;
            end
            m_prev = d;
        end
        if (m_serr == 1) begin
            m_sticky = 1;
            m_cnt  = clr_err ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            m_cnt2 = clr_err ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
        end else if (clr_err) begin
            m_sticky = 0;
            m_cnt    = 0;
            m_cnt2   = 0;
        end
    endtask

    task automatic compare_all();
        check("bin_out",    32'(bin_out),    32'(m_bin));
        check("bin_vld",    32'(bin_vld),    32'(m_bvld));
        check("locked",     32'(locked),     32'(m_mode == 2));
        check("wrap",       32'(wrap),       32'(m_wrap));
        check("step_err",   32'(step_err),   32'(m_serr));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        check("err_cnt",    32'(err_cnt),    32'(m_cnt));
        check("err_cnt_e2", 32'(err_cnt2),   32'(m_cnt2));
        check("locked_e2",  32'(locked2),    32'(m_mode == 2));
    endtask

    // Drive one cycle of inputs, let the edge pass, then compare away from it
    task automatic cycle(input bit r, input bit v, input int n, input bit c);
        rst_n    = r;
        gray_vld = v;
        gray_in  = CBITS'(n ^ (n >> 1));
        clr_err  = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic feed(input int n);
        cycle(1'b1, 1'b1, n, 1'b0);
    endtask

    initial begin
        int p, cnt, r;
        for (int n = 0; n <= MAXV; n++) inv_tab[n ^ (n >> 1)] = n;
        rst_n = 1'b0; gray_vld = 1'b0; clr_err = 1'b0; gray_in = '0;

        // Reset, then a clean count up through lock, a skip and relock
        cycle(1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b1, 7, 1'b0);
        for (int n = 0; n <= 10; n++) feed(n);
        feed(12);
        for (int n = 13; n <= 16; n++) feed(n);

        // Repeated samples separated by gaps are holds
        cycle(1'b0, 1'b0, 0, 1'b0);
        feed(5);
        cycle(1'b1, 1'b0, 0, 1'b0);
        feed(5);
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0);
        feed(5);
        feed(6);

        // clr_err together with a bad step, then repeated forced errors
        cycle(1'b0, 1'b0, 0, 1'b0);
        for (int n = 20; n <= 24; n++) feed(n);
        cycle(1'b1, 1'b1, 30, 1'b1);
        p = 30;
        for (int k = 0; k < 5; k++) begin
            for (int j = 1; j <= 4; j++) feed(p + j);
            feed(p + 14);
            p = p + 14;
        end
        cycle(1'b1, 1'b0, 0, 1'b1);

        // Wrap from the top count to zero
        cycle(1'b0, 1'b0, 0, 1'b0);
        for (int n = 250; n <= MAXV; n++) feed(n);
        feed(0);
        feed(1);

        // Reset while tracking discards the sample; next one restarts lock
        cycle(1'b0, 1'b1, 2, 1'b0);
        feed(9);
        feed(10);

        // Random stimulus
        cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      cnt = (cnt + 1) % (MAXV + 1);
            else if (r < 80) cnt = cnt;
            else if (r < 92) cnt = $urandom_range(0, MAXV);
            else             cnt = $urandom_range(MAXV - 6, MAXV);
            cycle(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 85),
                  cnt, ($urandom_range(0, 99) < 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_step_monitor.md
# gray_step_monitor

Downstream consumer of the free-running Gray-code counter. Samples the Gray code each valid cycle, decodes it to binary, and checks that consecutive samples advance by exactly one count modulo 2^CBITS. Acquires lock after a run of good steps and reports step errors, wrap events and an error count to the surrounding safety/liveness checking logic.

## Interface
- CBITS, 8, width of Gray code and decoded binary value
- LOCK_N, 4, consecutive good steps needed to enter TRACK (legal range 1..15)
- ECW, 8, width of saturating error counter
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  reset, synchronous and active-low (single clock domain)
- gray_in  in  CBITS  Gray code from upstream counter
- gray_vld  in  1  gray_in is a valid sample this cycle
- clr_err  in  1  clears err_sticky and err_cnt
- bin_out  out  CBITS  registered binary decode of last valid sample
- bin_vld  out  1  bin_out updated this cycle
- locked  out  1  high while in TRACK
- wrap  out  1  one-cycle pulse on a good step from 2^CBITS-1 to 0
- step_err  out  1  one-cycle pulse on a bad step while in TRACK
- err_sticky  out  1  set by any step_err; held until clr_err
- err_cnt  out  ECW  count of step_err pulses, saturating at 2^ECW-1

## Operation
- Decode: b[CBITS-1] = g[CBITS-1]; b[i] = b[i+1] ^ g[i] for i = CBITS-2 down to 0.
- prev holds the binary value of the last accepted sample. Step classification on each valid sample with decode d:
  - good: d == prev+1, computed in CBITS bits (wrapping)
  - hold: d == prev; ignored (no counter change, no state change, no error)
  - bad: any other value
- States are IDLE, LOCK and TRACK. Reset enters IDLE.
- IDLE: first valid sample loads prev and moves to LOCK with good_cnt = 0. No step check is made.
- LOCK:
  - good step: good_cnt++; when good_cnt reaches LOCK_N, move to TRACK.
  - bad step: good_cnt = 0 and stay in LOCK. No step_err.
- TRACK:
  - good step: stay in TRACK.
  - bad step: pulse step_err, set err_sticky, increment err_cnt (saturating), move to LOCK with good_cnt = 0.
- prev is updated on every valid sample, whether good or bad.
- wrap pulses on a good step with prev = 2^CBITS-1 and d = 0, in LOCK or TRACK.
- clr_err zeroes err_sticky and err_cnt at the next edge. If a step_err occurs in the same cycle, the error wins: err_sticky = 1 and err_cnt = 1.
- gray_vld low: bin_vld = 0. bin_out, prev, state and good_cnt hold.

## Timing
- Latency 1 cycle: a sample valid at edge t gives bin_out, bin_vld, wrap, step_err and locked at t+1.
- locked rises in the same cycle bin_vld shows the LOCK_N-th good sample. It falls in the same cycle step_err pulses.
- Reset values (rst_n low at an edge): bin_out 0, bin_vld 0, locked 0, wrap 0, step_err 0, err_sticky 0, err_cnt 0, good_cnt 0, prev 0, state IDLE.
- Reset mid-operation aborts immediately. Any sample presented with rst_n low is discarded.
- No backpressure: every valid sample is accepted.

## Test plan
- Reset, then feed gray(0..4) on consecutive cycles -> bin_out 0,1,2,3,4 one cycle later; locked = 1 from the cycle bin_out = 4; step_err never asserts.
- Lock, then feed gray(254), gray(255), gray(0) -> wrap pulses one cycle with bin_out = 0; locked stays 1; no step_err.
- Locked at 10, feed gray(12) -> step_err pulse, err_cnt = 1, err_sticky = 1, locked = 0. Then gray(13..16) -> locked = 1 again with bin_out = 16.
- Repeat gray(5) twice with gray_vld gaps between samples -> no error; bin_vld = 0 during gaps; state unchanged.
- clr_err in the same cycle as a bad step -> err_cnt = 1, err_sticky = 1. With ECW = 2 and 5 forced errors -> err_cnt = 3.
- Assert rst_n = 0 for one cycle while in TRACK -> every output is at its reset value next cycle; the next valid sample is treated as the first (IDLE to LOCK).
